// File: rtl/hms_set_cnt.sv
// hms_set_cnt: hours/minutes/seconds counter with an interactive SET mode.
// CLOCK mode counts 1 Hz ticks with full carry. SET mode freezes time and lets
// the user pick a field (i_pos) and bump it (i_incr) without carry.
// Input protocol: i_tick, i_mode, i_pos and i_incr are plain level-sampled
// events. Every cycle an input is high counts as one event. There is no
// edge detection and no valid/ready backpressure; the block accepts every
// event on the rising edge where it is sampled.
module hms_set_cnt #(
    parameter int P_HOUR_MAX = 23
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_tick,
    input  logic        i_mode,
    input  logic        i_pos,
    input  logic        i_incr,
    output logic [23:0] o_bcd,
    output logic [5:0]  o_six_dp,
    output logic        o_mode,
    output logic [1:0]  o_field
);

    typedef enum logic {
        ST_CLOCK = 1'b0,
        ST_SET   = 1'b1
    } state_t;

    localparam logic [1:0] F_SEC  = 2'd0;
    localparam logic [1:0] F_MIN  = 2'd1;
    localparam logic [1:0] F_HOUR = 2'd2;

    localparam logic [5:0] LAST_MS   = 6'd59;
    localparam logic [4:0] LAST_HOUR = 5'(P_HOUR_MAX);

    state_t     state_q, state_d;
    logic [1:0] field_q, field_d;
    logic [5:0] sec_q, sec_d;
    logic [5:0] min_q, min_d;
    logic [4:0] hour_q, hour_d;

    // Binary 0..59 to two BCD digits {tens, ones}.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        to_bcd = {4'(v / 6'd10), 4'(v % 6'd10)};
    endfunction

    // State, field and time registers; reset returns to 00:00:00 in CLOCK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLOCK;
            field_q <= F_SEC;
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= '0;
        end else begin
            state_q <= state_d;
            field_q <= field_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
        end
    end

    // Next-state logic: tick counting in CLOCK, field editing in SET.
    always_comb begin
        state_d = state_q;
        field_d = (field_q == 2'd3) ? F_SEC : field_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;

        case (state_q)
            ST_CLOCK: begin
                // The field register only matters in SET; keep it parked.
                field_d = F_SEC;
                if (i_tick) begin
                    if (sec_q == LAST_MS) begin
                        sec_d = '0;
                        if (min_q == LAST_MS) begin
                            min_d  = '0;
                            hour_d = (hour_q == LAST_HOUR) ? 5'd0 : hour_q + 5'd1;
                        end else begin
                            min_d = min_q + 6'd1;
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end
                // A tick in the same cycle still lands before entering SET.
                if (i_mode) begin
                    state_d = ST_SET;
                end
            end

            ST_SET: begin
                if (i_mode) begin
                    // Leaving SET wins over any same-cycle edit request.
                    state_d = ST_CLOCK;
                    field_d = F_SEC;
                end else begin
                    // Increment uses the field selected before this edge.
                    if (i_incr) begin
                        case (field_q)
                            F_SEC:   sec_d  = (sec_q  == LAST_MS)   ? 6'd0 : sec_q  + 6'd1;
                            F_MIN:   min_d  = (min_q  == LAST_MS)   ? 6'd0 : min_q  + 6'd1;
                            F_HOUR:  hour_d = (hour_q == LAST_HOUR) ? 5'd0 : hour_q + 5'd1;
                            default: ;
                        endcase
                    end
                    if (i_pos) begin
                        case (field_q)
                            F_SEC:   field_d = F_MIN;
                            F_MIN:   field_d = F_HOUR;
                            default: field_d = F_SEC;
                        endcase
                    end
                end
            end

            default: begin
                state_d = ST_CLOCK;
                field_d = F_SEC;
            end
        endcase
    end

    // Display data and decimal-point highlight for the field being edited.
    always_comb begin
        o_bcd    = {to_bcd({1'b0, hour_q}), to_bcd(min_q), to_bcd(sec_q)};
        o_six_dp = 6'b000000;
        if (state_q == ST_SET) begin
            case (field_q)
                F_SEC:   o_six_dp = 6'b000011;
                F_MIN:   o_six_dp = 6'b001100;
                F_HOUR:  o_six_dp = 6'b110000;
                default: o_six_dp = 6'b000000;
            endcase
        end
    end

    assign o_mode  = (state_q == ST_SET);
    assign o_field = field_q;

endmodule

// File: tb/tb_hms_set_cnt.sv
// Directed bench for hms_set_cnt: hand-computed vectors applied in sequence,
// each output compared with an immediate assertion.
module tb_hms_set_cnt;

    logic        clk;
    logic        rst;
    logic        i_tick;
    logic        i_mode;
    logic        i_pos;
    logic        i_incr;
    logic [23:0] o_bcd;
    logic [5:0]  o_six_dp;
    logic        o_mode;
    logic [1:0]  o_field;

    int vectors;
    int miscompares;

    hms_set_cnt #(.P_HOUR_MAX(23)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_tick   (i_tick),
        .i_mode   (i_mode),
        .i_pos    (i_pos),
        .i_incr   (i_incr),
        .o_bcd    (o_bcd),
        .o_six_dp (o_six_dp),
        .o_mode   (o_mode),
        .o_field  (o_field)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison point
    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Driver: starting at a falling edge, hold the pulses across one rising
    // edge and release them at the next falling edge.
    task automatic step(input logic t, input logic m, input logic p, input logic n);
        i_tick = t;
        i_mode = m;
        i_pos  = p;
        i_incr = n;
        @(negedge clk);
        i_tick = 1'b0;
        i_mode = 1'b0;
        i_pos  = 1'b0;
        i_incr = 1'b0;
    endtask

    task automatic repeat_step(input int cnt, input logic t, input logic m, input logic p, input logic n);
        for (int k = 0; k < cnt; k++) step(t, m, p, n);
    endtask

    task automatic check_all(input string tag, input logic [23:0] bcd, input logic [5:0] dp,
                             input logic mode, input logic [1:0] field);
        check({tag, "_bcd"},   o_bcd, bcd);
        check({tag, "_dp"},    {18'd0, o_six_dp}, {18'd0, dp});
        check({tag, "_mode"},  {23'd0, o_mode}, {23'd0, mode});
        check({tag, "_field"}, {22'd0, o_field}, {22'd0, field});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst    = 1'b1;
        i_tick = 1'b0;
        i_mode = 1'b0;
        i_pos  = 1'b0;
        i_incr = 1'b0;

        // Reset state, clock running
        repeat (3) @(negedge clk);
        check_all("reset", 24'h000000, 6'b000000, 1'b0, 2'd0);
        rst = 1'b0;

        // First event after reset is accepted at the first edge
        step(1, 0, 0, 0);
        check("first_tick", o_bcd, 24'h000001);

        // 61 ticks total: 00:01:01
        repeat_step(60, 1, 0, 0, 0);
        check("tick61_bcd", o_bcd, 24'h000101);
        check("tick61_mode", {23'd0, o_mode}, 24'd0);

        // Enter SET, load 23:59:59 field by field
        step(0, 1, 0, 0);
        check_all("set_enter", 24'h000101, 6'b000011, 1'b1, 2'd0);
        repeat_step(58, 0, 0, 0, 1);
        check("set_sec59", o_bcd, 24'h000159);
        step(0, 0, 1, 0);
        check_all("pos_min", 24'h000159, 6'b001100, 1'b1, 2'd1);
        repeat_step(58, 0, 0, 0, 1);
        check("set_min59", o_bcd, 24'h005959);
        step(0, 0, 1, 0);
        check_all("pos_hour", 24'h005959, 6'b110000, 1'b1, 2'd2);
        repeat_step(23, 0, 0, 0, 1);
        check("set_hour23", o_bcd, 24'h235959);
        // Hour wraps with no carry elsewhere, then back to 23
        step(0, 0, 0, 1);
        check("hour_wrap", o_bcd, 24'h005959);
        repeat_step(23, 0, 0, 0, 1);
        check("hour_back23", o_bcd, 24'h235959);

        // Exit to CLOCK, one tick rolls everything over
        step(0, 1, 0, 0);
        check_all("set_exit", 24'h235959, 6'b000000, 1'b0, 2'd0);
        step(1, 0, 0, 0);
        check("midnight", o_bcd, 24'h000000);

        // Field cycling in SET
        step(0, 1, 0, 0);
        check_all("cyc0", 24'h000000, 6'b000011, 1'b1, 2'd0);
        step(0, 0, 1, 0);
        check_all("cyc1", 24'h000000, 6'b001100, 1'b1, 2'd1);
        step(0, 0, 1, 0);
        check_all("cyc2", 24'h000000, 6'b110000, 1'b1, 2'd2);
        step(0, 0, 1, 0);
        check_all("cyc3", 24'h000000, 6'b000011, 1'b1, 2'd0);

        // min=03, back to SEC, sec=59; ticks frozen; incr wraps sec only
        step(0, 0, 1, 0);
        repeat_step(3, 0, 0, 0, 1);
        check("min3", o_bcd, 24'h000300);
        repeat_step(2, 0, 0, 1, 0);
        check("back_sec", {22'd0, o_field}, 24'd0);
        repeat_step(59, 0, 0, 0, 1);
        check("sec59_min3", o_bcd, 24'h000359);
        repeat_step(5, 1, 0, 0, 0);
        check("frozen", o_bcd, 24'h000359);
        step(0, 0, 0, 1);
        check("sec_wrap_nocarry", o_bcd, 24'h000300);

        // pos+incr together: increment old field, advance field
        step(0, 0, 1, 1);
        check_all("pos_incr", 24'h000301, 6'b001100, 1'b1, 2'd1);

        // mode+pos+incr in SET: exit, edits dropped
        step(0, 1, 1, 1);
        check_all("exit_drop", 24'h000301, 6'b000000, 1'b0, 2'd0);

        // CLOCK ignores pos/incr
        step(0, 0, 1, 1);
        check_all("clock_ignore", 24'h000301, 6'b000000, 1'b0, 2'd0);

        // Reset, reach 00:00:59, then mode+tick together
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst2", o_bcd, 24'h000000);
        repeat_step(59, 1, 0, 0, 0);
        check("at59", o_bcd, 24'h000059);
        step(1, 1, 0, 0);
        check_all("mode_tick", 24'h000100, 6'b000011, 1'b1, 2'd0);

        // Build 12:34:56 in SET from 00:01:00
        repeat_step(56, 0, 0, 0, 1);
        step(0, 0, 1, 0);
        repeat_step(33, 0, 0, 0, 1);
        step(0, 0, 1, 0);
        repeat_step(12, 0, 0, 0, 1);
        check_all("t123456", 24'h123456, 6'b110000, 1'b1, 2'd2);

        // Asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 24'h000000, 6'b000000, 1'b0, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 0, 0);
        check_all("post_rst_tick", 24'h000001, 6'b000000, 1'b0, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
